// File: rtl/cernbe_pkg.sv
// Shared types and constants for the Wishbone to cern-be-vme bridge.
package cernbe_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam int unsigned CERNBE_DATA_W = 32;

  function automatic int unsigned timer_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/cernbe_wait_timer.sv
// Wait-state cycle counter; expired is high in the TIMEOUT-th enabled cycle.
module cernbe_wait_timer
  import cernbe_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = timer_width(TIMEOUT);

  logic [W-1:0] cnt;

  // cnt holds the number of wait cycles already completed
  assign expired = en && (cnt == W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/wb_to_cernbe_master.sv
// Converts single Wishbone slave accesses into cern-be-vme read/write strobes.
module wb_to_cernbe_master
  import cernbe_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                     Clk,
  input  logic                     rst_n,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [ADDR_WIDTH-1:2]    wb_adr_i,
  input  logic [3:0]               wb_sel_i,
  input  logic [CERNBE_DATA_W-1:0] wb_dat_i,
  output logic [CERNBE_DATA_W-1:0] wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic                     wb_stall_o,
  output logic [ADDR_WIDTH-1:2]    VMEAddr,
  output logic [CERNBE_DATA_W-1:0] VMEWrData,
  output logic                     VMERdMem,
  output logic                     VMEWrMem,
  input  logic [CERNBE_DATA_W-1:0] VMERdData,
  input  logic                     VMERdDone,
  input  logic                     VMEWrDone
);

  state_t                   state, state_d;
  logic                     abandon, abandon_d;
  logic                     ack_d, err_d, stall_d, rdmem_d, wrmem_d;
  logic [ADDR_WIDTH-1:2]    addr_d;
  logic [CERNBE_DATA_W-1:0] wdata_d, rdat_d;
  logic                     in_wait, timer_clr, expired, done_match;

  assign in_wait    = (state == RD_WAIT) || (state == WR_WAIT);
  assign timer_clr  = (state == IDLE);
  assign done_match = ((state == RD_WAIT) && VMERdDone) || ((state == WR_WAIT) && VMEWrDone);

  cernbe_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (Clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .en      (in_wait),
    .expired (expired)
  );

  always_comb begin
    state_d   = state;
    abandon_d = abandon;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdmem_d   = 1'b0;
    wrmem_d   = 1'b0;
    addr_d    = VMEAddr;
    wdata_d   = VMEWrData;
    rdat_d    = wb_dat_o;
    case (state)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          addr_d    = wb_adr_i;
          wdata_d   = wb_dat_i;
          abandon_d = 1'b0;
          if (!wb_we_i) begin
            rdmem_d = 1'b1;
            state_d = RD_WAIT;
          end else if (wb_sel_i != 4'hF) begin
            err_d = 1'b1;
          end else begin
            wrmem_d = 1'b1;
            state_d = WR_WAIT;
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        // a dropped cycle only silences the response; the slave access runs on
        if (!wb_cyc_i) abandon_d = 1'b1;
        if (done_match) begin
          if (state == RD_WAIT) rdat_d = VMERdData;
          ack_d   = !abandon_d;
          state_d = RESP;
        end else if (expired) begin
          err_d   = !abandon_d;
          state_d = IDLE;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    stall_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      abandon    <= 1'b0;
      wb_dat_o   <= '0;
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      wb_stall_o <= 1'b0;
      VMEAddr    <= '0;
      VMEWrData  <= '0;
      VMERdMem   <= 1'b0;
      VMEWrMem   <= 1'b0;
    end else begin
      state      <= state_d;
      abandon    <= abandon_d;
      wb_dat_o   <= rdat_d;
      wb_ack_o   <= ack_d;
      wb_err_o   <= err_d;
      wb_stall_o <= stall_d;
      VMEAddr    <= addr_d;
      VMEWrData  <= wdata_d;
      VMERdMem   <= rdmem_d;
      VMEWrMem   <= wrmem_d;
    end
  end

endmodule

// File: tb/tb_wb_to_cernbe_master.sv
// Directed bench for wb_to_cernbe_master with TIMEOUT=4.
module tb_wb_to_cernbe_master;

  localparam int unsigned AW = 3;
  localparam int unsigned TO = 4;

  logic          Clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [AW-1:2] wb_adr_i = '0;
  logic [3:0]    wb_sel_i = '0;
  logic [31:0]   wb_dat_i = '0;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o, wb_err_o, wb_stall_o;
  logic [AW-1:2] VMEAddr;
  logic [31:0]   VMEWrData;
  logic          VMERdMem, VMEWrMem;
  logic [31:0]   VMERdData = '0;
  logic          VMERdDone = 1'b0, VMEWrDone = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  wb_to_cernbe_master #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .rst_n(rst_n),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .wb_stall_o(wb_stall_o), .VMEAddr(VMEAddr), .VMEWrData(VMEWrData),
    .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem), .VMERdData(VMERdData),
    .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone)
  );

  typedef struct {
    logic          we;
    logic [AW-1:2] adr;
    logic [3:0]    sel;
    logic [31:0]   wdat;
    logic [31:0]   rdat;
    int            done_c;
    int            wrong_c;
    int            exp_rsp_c;
    logic          exp_ack;
    int            exp_strobes;
  } vec_t;

  task automatic check(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (case %0d): got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // cycle c counts from the accept edge; a Done driven in cycle c is sampled at its end
  task automatic run_vec(input vec_t v, input int idx);
    int rd_n = 0, wr_n = 0, ack_n = 0, err_n = 0, rsp_c = 0;
    logic [31:0]   dat = '0;
    logic [31:0]   sd = '0;
    logic [AW-1:2] sa = '0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = v.we;
    wb_adr_i = v.adr; wb_sel_i = v.sel; wb_dat_i = v.wdat;
    tick();
    wb_stb_i = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (VMERdMem) begin rd_n++; sa = VMEAddr; end
      if (VMEWrMem) begin wr_n++; sa = VMEAddr; sd = VMEWrData; end
      if (wb_ack_o) begin ack_n++; if (rsp_c == 0) rsp_c = c; dat = wb_dat_o; end
      if (wb_err_o) begin err_n++; if (rsp_c == 0) rsp_c = c; end
      if (rsp_c != 0) wb_cyc_i = 1'b0;
      VMERdDone = (c == v.done_c && !v.we) || (c == v.wrong_c && v.we);
      VMEWrDone = (c == v.done_c && v.we) || (c == v.wrong_c && !v.we);
      VMERdData = (c == v.done_c) ? v.rdat : 32'hBAD0_0000;
      tick();
    end
    VMERdDone = 1'b0; VMEWrDone = 1'b0; wb_cyc_i = 1'b0;
    check("rd_strobes", idx, rd_n, v.we ? 0 : v.exp_strobes);
    check("wr_strobes", idx, wr_n, v.we ? v.exp_strobes : 0);
    check("ack_count", idx, ack_n, v.exp_ack ? 1 : 0);
    check("err_count", idx, err_n, v.exp_ack ? 0 : 1);
    check("rsp_cycle", idx, rsp_c, v.exp_rsp_c);
    if (v.exp_strobes != 0) check("strobe_addr", idx, sa, v.adr);
    if (v.we && v.exp_strobes != 0) check("strobe_wdata", idx, sd, v.wdat);
    if (!v.we && v.exp_ack) check("rd_data", idx, dat, v.rdat);
  endtask

  vec_t vecs[7];

  initial begin
    int ack_n, err_n;
    //           we    adr   sel    wdat          rdat          done wrong rsp ack strobes
    vecs[0] = '{1'b0, 1'b1, 4'h0, 32'h0,        32'hDEADBEEF, 2, 0, 3, 1'b1, 1};
    vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h12345678, 32'h0,        1, 0, 2, 1'b1, 1};
    vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h55AA55AA, 32'h0,        1, 0, 1, 1'b0, 0};
    vecs[3] = '{1'b0, 1'b0, 4'hF, 32'h0,        32'h11111111, 7, 0, 5, 1'b0, 1};
    vecs[4] = '{1'b0, 1'b0, 4'h5, 32'h0,        32'hCAFEF00D, 3, 1, 4, 1'b1, 1};
    vecs[5] = '{1'b1, 1'b1, 4'hF, 32'hA5A5C3C3, 32'h0,        4, 0, 5, 1'b1, 1};
    vecs[6] = '{1'b0, 1'b1, 4'hF, 32'h0,        32'h77778888, 5, 0, 5, 1'b0, 1};

    #12;
    check("reset_outputs", 0,
          {wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o, VMEAddr, VMEWrData, VMERdMem, VMEWrMem}, '0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // sel-rejected write, then a read accepted in the very next cycle
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'h3; wb_adr_i = 1'b1;
    wb_dat_i = 32'h01020304;
    tick();
    check("selerr_err", 10, {wb_err_o, wb_stall_o, VMEWrMem}, 3'b100);
    wb_we_i = 1'b0; wb_adr_i = 1'b0; wb_sel_i = 4'h0;
    tick();
    wb_stb_i = 1'b0;
    check("b2b_rdmem", 10, {VMERdMem, wb_err_o, wb_stall_o, VMEAddr}, 4'b1010);
    VMERdDone = 1'b1; VMERdData = 32'h0BADF00D;
    tick();
    VMERdDone = 1'b0; wb_cyc_i = 1'b0;
    check("b2b_ack", 10, {wb_ack_o, wb_dat_o}, {1'b1, 32'h0BADF00D});
    tick();
    check("b2b_idle", 10, {wb_ack_o, wb_stall_o}, 2'b00);

    // cycle abandoned mid-wait: slave still completes, no response
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 1'b1;
    tick();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    ack_n = 0; err_n = 0;
    for (int c = 1; c <= 8; c++) begin
      if (wb_ack_o) ack_n++;
      if (wb_err_o) err_n++;
      VMERdDone = (c == 2);
      VMERdData = 32'h99990000;
      tick();
    end
    VMERdDone = 1'b0;
    check("abandon_resp", 11, {ack_n[7:0], err_n[7:0]}, 16'h0);
    check("abandon_idle", 11, wb_stall_o, 1'b0);

    // asynchronous reset during WR_WAIT
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'hF; wb_adr_i = 1'b1;
    wb_dat_i = 32'hFEEDFACE;
    tick();
    wb_stb_i = 1'b0;
    check("rst_pre_strobe", 12, {VMEWrMem, wb_stall_o, VMEWrData}, {2'b11, 32'hFEEDFACE});
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_clear", 12,
          {wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o, VMEAddr, VMEWrData, VMERdMem, VMEWrMem}, '0);
    tick();
    rst_n = 1'b1; wb_cyc_i = 1'b0; VMEWrDone = 1'b1;
    tick();
    VMEWrDone = 1'b0;
    check("rst_stray_done", 12, {wb_ack_o, wb_err_o, wb_stall_o}, 3'b000);
    tick();
    check("rst_stray_done2", 12, {wb_ack_o, wb_err_o, wb_stall_o}, 3'b000);
    run_vec(vecs[0], 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
